// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Programmable raster timing generator. It produces the pixel-domain control
//   stream (de/hs/vs/x/y) and the active image size for the pattern generator
//   and HDMI transmit path. Timing requests are captured into shadow registers
//   only at frame boundaries, so a mode change never tears a frame.
//
// Ports
//   pixel_clk, reset_n          clock, asynchronous active-low reset
//   enable                      run timing (low = idle, current frame completes)
//   h_active/h_fp/h_sync/h_bp   horizontal timing request (pixels)
//   v_active/v_fp/v_sync/v_bp   vertical timing request (lines)
//   hs_pol, vs_pol              sync active-level request
//   pixel_de                    active video
//   pixel_hs, pixel_vs          syncs with polarity applied
//   pixel_x, pixel_y            active pixel coordinate, 0 outside active
//   image_width, image_height   shadow h_active / v_active
//   frame_start                 one-cycle pulse with pixel (0,0)
//   frame_cnt                   (VTG_FRAME_CNT_EN only) frame counter
//
// Build option
//   VTG_FRAME_CNT_EN : adds the 16-bit frame_cnt output.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter logic [11:0] DEF_H_ACTIVE = 12'd1280,
  parameter logic [11:0] DEF_H_FP     = 12'd110,
  parameter logic [11:0] DEF_H_SYNC   = 12'd40,
  parameter logic [11:0] DEF_H_BP     = 12'd220,
  parameter logic [11:0] DEF_V_ACTIVE = 12'd720,
  parameter logic [11:0] DEF_V_FP     = 12'd5,
  parameter logic [11:0] DEF_V_SYNC   = 12'd5,
  parameter logic [11:0] DEF_V_BP     = 12'd20,
  parameter logic        DEF_HS_POL   = 1'b1,
  parameter logic        DEF_VS_POL   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] h_active,
  input  logic [11:0] h_fp,
  input  logic [11:0] h_sync,
  input  logic [11:0] h_bp,
  input  logic [11:0] v_active,
  input  logic [11:0] v_fp,
  input  logic [11:0] v_sync,
  input  logic [11:0] v_bp,
  input  logic        hs_pol,
  input  logic        vs_pol,
  output logic        pixel_de,
  output logic        pixel_hs,
  output logic        pixel_vs,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic [11:0] image_width,
  output logic [11:0] image_height,
`ifdef VTG_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // A zero-width field would make a counter range empty; store it as 1.
  function automatic logic [11:0] nz(input logic [11:0] v);
    return (v == 12'd0) ? 12'd1 : v;
  endfunction

  function automatic logic [13:0] ext(input logic [11:0] v);
    return {2'b00, v};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [13:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

  logic [11:0] sh_h_act_q, sh_h_fp_q, sh_h_sync_q, sh_h_bp_q;
  logic [11:0] sh_v_act_q, sh_v_fp_q, sh_v_sync_q, sh_v_bp_q;
  logic        sh_hs_pol_q, sh_vs_pol_q;

  logic        de_q, hs_q, vs_q, fs_q;
  logic [11:0] x_q, y_q, img_w_q, img_h_q;

  // Derived boundaries, 14 bits so four maximal 12-bit fields cannot overflow.
  logic [13:0] h_ss, h_se, h_total, v_ss, v_se, v_total;
  logic        h_last, v_last, frame_end, run, load;
  logic        de_d, hs_in, vs_in, fs_d;

  always_comb begin
    h_ss    = ext(sh_h_act_q) + ext(sh_h_fp_q);
    h_se    = h_ss + ext(sh_h_sync_q);
    h_total = h_se + ext(sh_h_bp_q);
    v_ss    = ext(sh_v_act_q) + ext(sh_v_fp_q);
    v_se    = v_ss + ext(sh_v_sync_q);
    v_total = v_se + ext(sh_v_bp_q);
  end

  assign run       = (state_q == ST_RUN);
  assign h_last    = (h_cnt_q == h_total - 14'd1);
  assign v_last    = (v_cnt_q == v_total - 14'd1);
  assign frame_end = run && h_last && v_last;
  // Reload only when another frame follows; an idle exit reloads in LOAD.
  assign load      = (state_q == ST_LOAD) || (frame_end && enable);

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = 14'd0;
        v_cnt_d = 14'd0;
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        h_cnt_d = 14'd0;
        v_cnt_d = 14'd0;
        state_d = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (h_last) begin
          h_cnt_d = 14'd0;
          v_cnt_d = v_last ? 14'd0 : v_cnt_q + 14'd1;
        end else begin
          h_cnt_d = h_cnt_q + 14'd1;
        end
        // enable is only honoured at the frame end so frames are never cut.
        if (frame_end && !enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        h_cnt_d = 14'd0;
        v_cnt_d = 14'd0;
      end
    endcase
  end

  always_comb begin
    de_d  = run && (h_cnt_q < ext(sh_h_act_q)) && (v_cnt_q < ext(sh_v_act_q));
    hs_in = run && (h_cnt_q >= h_ss) && (h_cnt_q < h_se);
    vs_in = run && (v_cnt_q >= v_ss) && (v_cnt_q < v_se);
    fs_d  = run && (h_cnt_q == 14'd0) && (v_cnt_q == 14'd0);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= 14'd0;
      v_cnt_q <= 14'd0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_h_act_q  <= DEF_H_ACTIVE;
      sh_h_fp_q   <= DEF_H_FP;
      sh_h_sync_q <= DEF_H_SYNC;
      sh_h_bp_q   <= DEF_H_BP;
      sh_v_act_q  <= DEF_V_ACTIVE;
      sh_v_fp_q   <= DEF_V_FP;
      sh_v_sync_q <= DEF_V_SYNC;
      sh_v_bp_q   <= DEF_V_BP;
      sh_hs_pol_q <= DEF_HS_POL;
      sh_vs_pol_q <= DEF_VS_POL;
    end else if (load) begin
      sh_h_act_q  <= nz(h_active);
      sh_h_fp_q   <= nz(h_fp);
      sh_h_sync_q <= nz(h_sync);
      sh_h_bp_q   <= nz(h_bp);
      sh_v_act_q  <= nz(v_active);
      sh_v_fp_q   <= nz(v_fp);
      sh_v_sync_q <= nz(v_sync);
      sh_v_bp_q   <= nz(v_bp);
      sh_hs_pol_q <= hs_pol;
      sh_vs_pol_q <= vs_pol;
    end
  end

  // Output stage: one cycle behind the counters. image_width/height are
  // registered too so they change together with the first frame_start.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q    <= 1'b0;
      hs_q    <= ~DEF_HS_POL;
      vs_q    <= ~DEF_VS_POL;
      fs_q    <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      img_w_q <= DEF_H_ACTIVE;
      img_h_q <= DEF_V_ACTIVE;
    end else begin
      de_q    <= de_d;
      hs_q    <= hs_in ? sh_hs_pol_q : ~sh_hs_pol_q;
      vs_q    <= vs_in ? sh_vs_pol_q : ~sh_vs_pol_q;
      fs_q    <= fs_d;
      x_q     <= de_d ? h_cnt_q[11:0] : 12'd0;
      y_q     <= de_d ? v_cnt_q[11:0] : 12'd0;
      img_w_q <= sh_h_act_q;
      img_h_q <= sh_v_act_q;
    end
  end

  assign pixel_de     = de_q;
  assign pixel_hs     = hs_q;
  assign pixel_vs     = vs_q;
  assign pixel_x      = x_q;
  assign pixel_y      = y_q;
  assign image_width  = img_w_q;
  assign image_height = img_h_q;
  assign frame_start  = fs_q;

`ifdef VTG_FRAME_CNT_EN
  // Stepped with the same edge that raises frame_start, so the pulse cycle
  // already shows the new count.
  logic [15:0] frame_cnt_q;
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n)  frame_cnt_q <= 16'd0;
    else if (fs_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;
  logic        pixel_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] h_active = 12'd4, h_fp = 12'd1, h_sync = 12'd2, h_bp = 12'd1;
  logic [11:0] v_active = 12'd3, v_fp = 12'd1, v_sync = 12'd1, v_bp = 12'd1;
  logic        hs_pol = 1'b1, vs_pol = 1'b1;
  logic        pixel_de, pixel_hs, pixel_vs, frame_start;
  logic [11:0] pixel_x, pixel_y, image_width, image_height;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  video_timing_gen dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
    .pixel_de(pixel_de), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .image_width(image_width), .image_height(image_height),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Expected values for each frame_start (gap from previous start or from
  // enable rising, image size, frame count) and per-frame output statistics.
  typedef struct { int gap; int w; int h; int fc; } fs_t;
  typedef struct { int de; int hs; int vs; int xs; int ys; int hs1; int vs1; } fr_t;
  fs_t fs_q[$];
  fr_t fr_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  flush_req = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_fs(input int gap, input int w, input int h, input int fc);
    fs_t e;
    e.gap = gap; e.w = w; e.h = h; e.fc = fc;
    fs_q.push_back(e);
  endfunction

  function automatic void push_fr(input int de, input int hs, input int vs, input int xs,
                                  input int ys, input int hs1, input int vs1);
    fr_t e;
    e.de = de; e.hs = hs; e.vs = vs; e.xs = xs; e.ys = ys; e.hs1 = hs1; e.vs1 = vs1;
    fr_q.push_back(e);
  endfunction

  // h=4/1/2/1 v=3/1/1/1: 8-cycle lines, 6 lines; de 4x3, x sum 6 per line,
  // y sum 4*(0+1+2), hs at h 5-6 on all 6 lines, vs covers line 4 (offset 32).
  function automatic void push_fr_cfg1();
    push_fr(12, 12, 8, 18, 12, 5, 32);
  endfunction

  function automatic void check_fr(input fr_t s);
    fr_t e;
    if (fr_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL frame_stats: frame ended with no expected statistics queued");
    end else begin
      e = fr_q.pop_front();
      chk("frame_de_count", s.de, e.de);
      chk("frame_hs_count", s.hs, e.hs);
      chk("frame_vs_count", s.vs, e.vs);
      chk("frame_x_sum", s.xs, e.xs);
      chk("frame_y_sum", s.ys, e.ys);
      chk("frame_hs_first", s.hs1, e.hs1);
      chk("frame_vs_first", s.vs1, e.vs1);
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    int  cyc, off, flush_seen;
    bit  in_frame, en_prev;
    fr_t st;
    fs_t e;
    cyc = 0; off = 0; flush_seen = 0; in_frame = 0; en_prev = 0;
    st = '{0, 0, 0, 0, 0, -1, -1};
    forever begin
      @(posedge pixel_clk); #1;
      if (!reset_n) begin
        in_frame = 0; cyc = 0; en_prev = 0; flush_seen = flush_req;
        continue;
      end
      cyc++;
      if (enable && !en_prev) cyc = 0;
      en_prev = enable;
      if (flush_seen != flush_req) begin
        flush_seen = flush_req;
        if (in_frame) check_fr(st);
        in_frame = 0;
      end
      if (frame_start) begin
        if (in_frame) check_fr(st);
        if (fs_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_frame_start: got pulse after %0d cycles, expected none", cyc);
        end else begin
          e = fs_q.pop_front();
          chk("frame_start_gap", cyc, e.gap);
          chk("image_width", int'(image_width), e.w);
          chk("image_height", int'(image_height), e.h);
`ifdef VTG_FRAME_CNT_EN
          chk("frame_cnt", int'(frame_cnt), e.fc);
`endif
        end
        cyc = 0; off = 0; in_frame = 1;
        st = '{0, 0, 0, 0, 0, -1, -1};
      end
      if (in_frame) begin
        if (pixel_de) begin
          st.de++; st.xs += int'(pixel_x); st.ys += int'(pixel_y);
        end
        if (pixel_hs) begin
          st.hs++; if (st.hs1 < 0) st.hs1 = off;
        end
        if (pixel_vs) begin
          st.vs++; if (st.vs1 < 0) st.vs1 = off;
        end
        off++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pixel_clk);
      n++;
    end while (!frame_start && n < 200);
    if (!frame_start) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no frame_start within 200 cycles, expected one", name);
    end
  endtask

  initial begin : stim
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(20);
    chk("reset_de", int'(pixel_de), 0);
    chk("reset_hs", int'(pixel_hs), 0);
    chk("reset_vs", int'(pixel_vs), 0);
    chk("reset_x", int'(pixel_x), 0);
    chk("reset_y", int'(pixel_y), 0);
    chk("reset_width", int'(image_width), 1280);
    chk("reset_height", int'(image_height), 720);
`ifdef VTG_FRAME_CNT_EN
    chk("reset_frame_cnt", int'(frame_cnt), 0);
`endif

    // Frames 1-3 at 8-cycle lines; h_active=6 requested mid frame 3 takes
    // effect in frame 4 (10-cycle lines, hs at h 7-8, vs line 4 at offset 40).
    push_fs(2, 4, 3, 1);
    push_fs(48, 4, 3, 2);
    push_fs(48, 4, 3, 3);
    push_fs(48, 6, 3, 4);
    push_fr_cfg1(); push_fr_cfg1(); push_fr_cfg1();
    push_fr(18, 12, 10, 45, 18, 7, 40);
    enable = 1'b1;
    wait_fs("frame1");
    wait_fs("frame2");
    wait_fs("frame3");
    wait_cyc(20);
    h_active = 12'd6;
    wait_fs("frame4");

    // h_sync=0 and v_fp=0 act as 1: 7-cycle lines, single hs cycle at h 5.
    h_active = 12'd4; h_sync = 12'd0; v_fp = 12'd0;
    push_fs(60, 4, 3, 5);
    push_fr(12, 6, 7, 18, 12, 5, 28);
    wait_fs("frame5");

    // Back to the 48-cycle frame; drop enable on line 1, frame must finish.
    h_sync = 12'd2; v_fp = 12'd1;
    push_fs(42, 4, 3, 6);
    push_fr_cfg1();
    wait_fs("frame6");
    wait_cyc(10);
    enable = 1'b0;
    wait_cyc(60);
    chk("idle_de", int'(pixel_de), 0);
    chk("idle_hs", int'(pixel_hs), 0);
    chk("idle_vs", int'(pixel_vs), 0);
    chk("idle_x", int'(pixel_x), 0);
    chk("idle_width", int'(image_width), 4);
    flush_req++;

    // Re-enable: frame_start 2 cycles after LOAD; drop enable at once.
    push_fs(2, 4, 3, 7);
    push_fr_cfg1();
    wait_cyc(2);
    enable = 1'b1;
    wait_fs("frame7");
    enable = 1'b0;
    wait_cyc(60);
    flush_req++;

    // Asynchronous reset on line 1 while de is high.
    push_fs(2, 4, 3, 8);
    wait_cyc(2);
    enable = 1'b1;
    wait_fs("frame8");
    wait_cyc(10);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_de", int'(pixel_de), 0);
    chk("async_rst_x", int'(pixel_x), 0);
    chk("async_rst_y", int'(pixel_y), 0);
    chk("async_rst_hs", int'(pixel_hs), 0);
    chk("async_rst_width", int'(image_width), 1280);
    chk("async_rst_height", int'(image_height), 720);
`ifdef VTG_FRAME_CNT_EN
    chk("async_rst_frame_cnt", int'(frame_cnt), 0);
`endif
    enable = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("fs_queue_left", fs_q.size(), 0);
    chk("frame_queue_left", fr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
